// File: rtl/prbs31_sync_checker_pkg.sv
// Shared PRBS31 definitions.
// Holds the checker state encoding and the x^31 + x^28 + 1 polynomial
// constants used by both the generator and the checker, plus the
// one-step prediction helper.
package prbs_pkg;
  localparam int PRBS_ORDER = 31;
  localparam int PRBS_TAP   = 28;

  typedef enum logic [1:0] {
    ST_SEED,
    ST_VERIFY,
    ST_LOCKED
  } chk_state_e;

  // h[0] is the newest bit, so x^k lives at h[k-1].
  function automatic logic prbs_pred(input logic [PRBS_ORDER-1:0] h);
    return h[PRBS_TAP-1] ^ h[PRBS_ORDER-1];
  endfunction
endpackage

// File: rtl/prbs31_sync_checker_if.sv
// Bit-stream and statistics bundle for prbs31_sync_checker.
//   data_in / data_in_valid : recovered bit and its qualifier
//   clear                   : statistics clear pulse
//   locked                  : checker locked to the PRBS31 stream
//   total_bits / total_bit_errors / resync_count : statistics
// master = stream source / statistics reader, slave = checker.
interface prbs31_sync_checker_if #(
  parameter int COUNT_W = 32
);
  logic               data_in;
  logic               data_in_valid;
  logic               clear;
  logic               locked;
  logic [COUNT_W-1:0] total_bits;
  logic [COUNT_W-1:0] total_bit_errors;
  logic [7:0]         resync_count;

  modport master (
    output data_in, data_in_valid, clear,
    input  locked, total_bits, total_bit_errors, resync_count
  );

  modport slave (
    input  data_in, data_in_valid, clear,
    output locked, total_bits, total_bit_errors, resync_count
  );
endinterface

// File: rtl/prbs31_sync_checker_ber_window_monitor.sv
// Locked-mode error density monitor.
// Counts enabled bits modulo ERR_WINDOW (power of two) and the errors
// seen within the current window. resync_req fires combinationally on
// the enabled bit that brings the window error count to ERR_THRESH, so
// the parent can leave lock on that same bit.
//   clk, reset : clock, async active-high reset
//   en         : a locked, valid bit is being checked
//   err        : that bit mismatched the reference
//   resync_req : one-cycle request to re-synchronise
module ber_window_monitor #(
  parameter int ERR_WINDOW = 128,
  parameter int ERR_THRESH = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic err,
  output logic resync_req
);
  localparam int WW = $clog2(ERR_WINDOW);
  localparam int EW = $clog2(ERR_THRESH + 1);
  localparam logic [EW-1:0] THR_M1 = EW'(ERR_THRESH - 1);

  logic [WW-1:0] win_bits;
  logic [EW-1:0] win_errs;
  logic          wrap;

  // Threshold is evaluated before the wrap clear, so a threshold hit on
  // the last bit of a window still requests resync.
  always_comb begin
    wrap       = &win_bits;
    resync_req = en && err && (win_errs == THR_M1);
  end

  // Clearing on resync leaves the window aligned to the next lock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_bits <= '0;
      win_errs <= '0;
    end else if (en) begin
      if (resync_req || wrap) begin
        win_bits <= '0;
        win_errs <= '0;
      end else begin
        win_bits <= win_bits + 1'b1;
        win_errs <= win_errs + EW'(err);
      end
    end
  end
endmodule

// File: rtl/prbs31_sync_checker.sv
// Self-synchronising PRBS31 checker and bit-error counter.
// SEED loads 31 received bits into the history, VERIFY self-syncs and
// needs LOCK_COUNT consecutive matches, LOCKED free-runs the reference
// and counts bits/errors until the error density forces a reseed.
//   clk, reset : clock, async active-high reset
//   bus        : slave side of prbs31_sync_checker_if (stream in,
//                registered lock flag and statistics out)
module prbs31_sync_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_COUNT = 64,
  parameter int ERR_WINDOW = 128,
  parameter int ERR_THRESH = 16,
  parameter int COUNT_W    = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  prbs31_sync_checker_if.slave  bus
);
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam logic [MW-1:0] LOCK_M1   = MW'(LOCK_COUNT - 1);
  localparam logic [4:0]    SEED_LAST = 5'(PRBS_ORDER - 1);

  chk_state_e            state, state_nx;
  logic [PRBS_ORDER-1:0] h, h_nx;
  logic [4:0]            seed_cnt;
  logic [MW-1:0]         match_cnt;
  logic                  vld, p, mism, lock_en, resync_req;
  logic                  locked_q;
  logic [COUNT_W-1:0]    bits_q, errs_q;
  logic [7:0]            resync_q;

  always_comb begin
    vld     = bus.data_in_valid;
    p       = prbs_pred(h);
    mism    = bus.data_in ^ p;
    lock_en = vld && (state == ST_LOCKED);
    // Locked: shift the prediction so a channel error is counted once.
    h_nx    = {h[PRBS_ORDER-2:0], (state == ST_LOCKED) ? p : bus.data_in};
    state_nx = state;
    if (vld) begin
      case (state)
        ST_SEED:   if (seed_cnt == SEED_LAST && h_nx != '0) state_nx = ST_VERIFY;
        // A history that decays to zero would predict zeros forever and
        // lock onto a dead line, so fall back to seeding.
        ST_VERIFY: if (h_nx == '0) state_nx = ST_SEED;
                   else if (!mism && match_cnt == LOCK_M1) state_nx = ST_LOCKED;
        ST_LOCKED: if (resync_req) state_nx = ST_SEED;
        default:   state_nx = ST_SEED;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_SEED;
      locked_q <= 1'b0;
    end else begin
      state    <= state_nx;
      locked_q <= (state_nx == ST_LOCKED);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h         <= '0;
      seed_cnt  <= '0;
      match_cnt <= '0;
    end else if (vld) begin
      h <= h_nx;
      case (state)
        ST_SEED:   seed_cnt  <= (seed_cnt == SEED_LAST) ? '0 : seed_cnt + 1'b1;
        ST_VERIFY: match_cnt <= (mism || h_nx == '0) ? '0 : match_cnt + 1'b1;
        ST_LOCKED: if (resync_req) begin
                     seed_cnt  <= '0;
                     match_cnt <= '0;
                   end
        default:   ;
      endcase
    end
  end

  // clear beats a concurrent count; all statistics saturate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bits_q   <= '0;
      errs_q   <= '0;
      resync_q <= '0;
    end else if (bus.clear) begin
      bits_q   <= '0;
      errs_q   <= '0;
      resync_q <= '0;
    end else if (lock_en) begin
      if (~&bits_q)                 bits_q   <= bits_q + 1'b1;
      if (mism && ~&errs_q)         errs_q   <= errs_q + 1'b1;
      if (resync_req && ~&resync_q) resync_q <= resync_q + 1'b1;
    end
  end

  ber_window_monitor #(
    .ERR_WINDOW (ERR_WINDOW),
    .ERR_THRESH (ERR_THRESH)
  ) u_mon (
    .clk        (clk),
    .reset      (reset),
    .en         (lock_en),
    .err        (mism),
    .resync_req (resync_req)
  );

  assign bus.locked           = locked_q;
  assign bus.total_bits       = bits_q;
  assign bus.total_bit_errors = errs_q;
  assign bus.resync_count     = resync_q;
endmodule

// File: tb/tb_prbs31_sync_checker.sv
// Bench for prbs31_sync_checker: a 32-bit and an 8-bit counter instance
// see the same PRBS31 stream; expected statistics come from stimulus
// tables and stream arithmetic, queued at drive time and compared once
// the DUT has registered the bit.
module tb_prbs31_sync_checker;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  prbs31_sync_checker_if #(.COUNT_W(32)) bus ();
  prbs31_sync_checker_if #(.COUNT_W(8))  bus8 ();

  assign bus8.data_in       = bus.data_in;
  assign bus8.data_in_valid = bus.data_in_valid;
  assign bus8.clear         = bus.clear;

  prbs31_sync_checker dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  prbs31_sync_checker #(.COUNT_W(8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  typedef struct {
    string name;
    bit    lk;
    int    tb;
    int    te;
    int    rc;
  } exp_t;

  // flip: 0 none, 1 invert last bit of the row, 2 invert every bit
  typedef struct {
    string name;
    int    n;
    int    flip;
    bit    clr;
    bit    lk;
    int    tb;
    int    te;
    int    rc;
  } row_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [30:0] g = 31'h1234_5678;

  function automatic int sat8(input int x);
    return (x > 255) ? 255 : x;
  endfunction

  // Reference PRBS31 generator, x^31 + x^28 + 1.
  task automatic gen(output logic b);
    b = g[27] ^ g[30];
    g = {g[29:0], b};
  endtask

  task automatic push(input string n, input bit lk, input int tb, input int te, input int rc);
    exp_t e;
    e.name = n; e.lk = lk; e.tb = tb; e.te = te; e.rc = rc;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: got 0 queued entries, want 1");
      return;
    end
    e = sb.pop_front();
    if (bus.locked !== e.lk || bus.total_bits !== 32'(e.tb) ||
        bus.total_bit_errors !== 32'(e.te) || bus.resync_count !== 8'(e.rc)) begin
      errors++;
      $display("FAIL %s w32: got lk=%0b bits=%0d errs=%0d rs=%0d, want lk=%0b bits=%0d errs=%0d rs=%0d",
               e.name, bus.locked, bus.total_bits, bus.total_bit_errors, bus.resync_count,
               e.lk, e.tb, e.te, e.rc);
    end
    checks++;
    if (bus8.locked !== e.lk || bus8.total_bits !== 8'(sat8(e.tb)) ||
        bus8.total_bit_errors !== 8'(sat8(e.te)) || bus8.resync_count !== 8'(e.rc)) begin
      errors++;
      $display("FAIL %s w8: got lk=%0b bits=%0d errs=%0d rs=%0d, want lk=%0b bits=%0d errs=%0d rs=%0d",
               e.name, bus8.locked, bus8.total_bits, bus8.total_bit_errors, bus8.resync_count,
               e.lk, sat8(e.tb), sat8(e.te), e.rc);
    end
  endtask

  task automatic cyc(input logic d, input logic v, input logic clr);
    bus.data_in       = d;
    bus.data_in_valid = v;
    bus.clear         = clr;
    @(posedge clk);
    #1;
    bus.data_in_valid = 1'b0;
    bus.clear         = 1'b0;
  endtask

  task automatic do_reset();
    reset             = 1'b1;
    bus.data_in       = 1'b0;
    bus.data_in_valid = 1'b0;
    bus.clear         = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    row_t rows [13];
    int   k;

    // Lock at valid bit 95; windows of 128 start at locked bit 1, so
    // locked bits 10113..10128 sit inside one window.
    rows = '{
      '{"pre_lock",   94,   0, 1'b0, 1'b0, 0,     0,  0},
      '{"lock",       1,    0, 1'b0, 1'b1, 0,     0,  0},
      '{"sat300",     300,  0, 1'b0, 1'b1, 300,   0,  0},
      '{"clean499",   199,  0, 1'b0, 1'b1, 499,   0,  0},
      '{"err500",     1,    1, 1'b0, 1'b1, 500,   1,  0},
      '{"to10k",      9500, 0, 1'b0, 1'b1, 10000, 1,  0},
      '{"pre_burst",  112,  0, 1'b0, 1'b1, 10112, 1,  0},
      '{"burst15",    15,   2, 1'b0, 1'b1, 10127, 16, 0},
      '{"burst16",    1,    2, 1'b0, 1'b0, 10128, 17, 1},
      '{"relock_pre", 94,   0, 1'b0, 1'b0, 10128, 17, 1},
      '{"relock",     1,    0, 1'b0, 1'b1, 10128, 17, 1},
      '{"clear_err",  1,    1, 1'b1, 1'b1, 0,     0,  0},
      '{"post_clear", 10,   0, 1'b0, 1'b1, 10,    0,  0}
    };

    do_reset();
    push("reset", 1'b0, 0, 0, 0);
    check_out();

    foreach (rows[r]) begin
      for (int i = 0; i < rows[r].n; i++) begin
        logic b;
        logic last;
        last = (i == rows[r].n - 1);
        gen(b);
        if (rows[r].flip == 2 || (rows[r].flip == 1 && last)) b = ~b;
        if (last) push(rows[r].name, rows[r].lk, rows[r].tb, rows[r].te, rows[r].rc);
        cyc(b, 1'b1, rows[r].clr && last);
        if (last) check_out();
      end
    end

    // Asynchronous reset while locked, sampled between clock edges.
    reset = 1'b1;
    #2;
    push("async_reset", 1'b0, 0, 0, 0);
    check_out();
    @(posedge clk);
    #1 reset = 1'b0;

    // All-zero line must never lock.
    for (int i = 0; i < 1000; i++) begin
      push("all_zero", 1'b0, 0, 0, 0);
      cyc(1'b0, 1'b1, 1'b0);
      check_out();
    end

    // ~30% valid duty with junk on invalid cycles; outputs follow only
    // the number of valid bits seen.
    do_reset();
    k = 0;
    for (int c = 0; c < 60000 && k < 10095; c++) begin
      logic v;
      logic b;
      v = ($urandom_range(99) < 30);
      if (v) begin
        gen(b);
        k++;
      end else begin
        b = 1'($urandom_range(1));
      end
      push("stall", k >= 95, (k > 95) ? k - 95 : 0, 0, 0);
      cyc(b, v, 1'b0);
      check_out();
    end
    checks++;
    if (k < 10095) begin
      errors++;
      $display("FAIL stall_budget: got %0d valid bits, want 10095", k);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
